semaforo_ctrl: RTL and testbench

- Traffic-light phase controller that sits directly downstream of the BCD countdown timer (0–29 s, tens 2 bits / units 4 bits).
- Consumes the timer's zero flag and "at 15" flag.
- Produces the timer's preset value, reload pulse and special-case hold, plus vehicle and pedestrian lamp outputs.
- Handles the pedestrian request (shortens green to 15 s) and a night mode (flashing amber).

---
 rtl/semaforo_ctrl_pkg.sv | 31 +++
 rtl/semaforo_ctrl_if.sv | 20 ++
 rtl/semaforo_ctrl_ped_latch.sv | 40 ++++
 rtl/semaforo_ctrl.sv | 163 ++++++++++++++++
 tb/tb_semaforo_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/semaforo_ctrl_pkg.sv
// Shared types and helpers for the traffic-light controller and its countdown timer.
package semaforo_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    VERDE,
    AMARELO,
    VERMELHO,
    NOTURNO
  } estado_t;

  // Reload value as seen by the timer: two BCD digits, tens first.
  typedef struct packed {
    logic [1:0] dez;
    logic [3:0] unid;
  } bcd_t;

  localparam int T_VERDE_DEF    = 29;
  localparam int T_AMARELO_DEF  = 5;
  localparam int T_VERMELHO_DEF = 20;
  localparam int T_CURTO_DEF    = 15;

  // Splits a duration in seconds (0..29) into BCD tens and units.
  function automatic bcd_t bcd_split(input int t);
    bcd_t r;
    r.dez  = 2'(t / 10);
    r.unid = 4'(t % 10);
    return r;
  endfunction

endpackage

// File: rtl/semaforo_ctrl_if.sv
// Link between the phase controller (master) and the BCD countdown timer (slave).
interface semaforo_ctrl_if;
  logic       tick;
  logic       fim;
  logic       quinze;
  logic       carga;
  logic [1:0] dez_preset;
  logic [3:0] unid_preset;
  logic       caso_esp;

  modport master (
    input  tick, fim, quinze,
    output carga, dez_preset, unid_preset, caso_esp
  );

  modport slave (
    output tick, fim, quinze,
    input  carga, dez_preset, unid_preset, caso_esp
  );
endinterface

// File: rtl/semaforo_ctrl_ped_latch.sv
// Pedestrian request latch plus the per-phase bookkeeping used to shorten green once.
module semaforo_ctrl_ped_latch (
  input  logic clock,
  input  logic reset,
  input  logic pedestre,
  input  logic quinze,
  input  logic limpa_pedido,
  input  logic inicio_fase,
  input  logic encurta,
  output logic pedido,
  output logic encurtado,
  output logic visto_quinze
);

  // Request is remembered until the pedestrians get their walk phase; clearing wins over a new press.
  always_ff @(posedge clock) begin
    if (reset) begin
      pedido <= 1'b0;
    end else if (limpa_pedido) begin
      pedido <= 1'b0;
    end else if (pedestre) begin
      pedido <= 1'b1;
    end
  end

  // Per-phase flags restart on every phase entry, but not on the shortening reload itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      encurtado    <= 1'b0;
      visto_quinze <= 1'b0;
    end else if (inicio_fase) begin
      encurtado    <= 1'b0;
      visto_quinze <= 1'b0;
    end else begin
      if (encurta) encurtado <= 1'b1;
      if (quinze) visto_quinze <= 1'b1;
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light phase controller driving the reload side of the BCD countdown timer.
module semaforo_ctrl
  import semaforo_ctrl_pkg::*;
#(
  parameter int T_VERDE    = T_VERDE_DEF,
  parameter int T_AMARELO  = T_AMARELO_DEF,
  parameter int T_VERMELHO = T_VERMELHO_DEF,
  parameter int T_CURTO    = T_CURTO_DEF
) (
  input  logic clock,
  input  logic reset,
  semaforo_ctrl_if.master tmr,
  input  logic pedestre,
  input  logic noturno,
  output logic verde,
  output logic amarelo,
  output logic vermelho,
  output logic ped_verde,
  output logic ped_vermelho
);

  localparam bcd_t P_VERDE    = bcd_split(T_VERDE);
  localparam bcd_t P_AMARELO  = bcd_split(T_AMARELO);
  localparam bcd_t P_VERMELHO = bcd_split(T_VERMELHO);
  localparam bcd_t P_CURTO    = bcd_split(T_CURTO);

  estado_t estado, estado_nx;
  logic    carga_q, carga_nx, caso_q;
  bcd_t    preset_q, preset_nx;
  logic    verde_nx, amarelo_nx, vermelho_nx, ped_verde_nx, ped_vermelho_nx;
  logic    armed, expira, encurta, inicio_fase, limpa_pedido;
  logic    pedido, encurtado, visto_quinze;

  assign tmr.carga       = carga_q;
  assign tmr.dez_preset  = preset_q.dez;
  assign tmr.unid_preset = preset_q.unid;
  assign tmr.caso_esp    = caso_q;

  assign inicio_fase  = carga_nx & ~encurta;
  assign limpa_pedido = ((estado_nx == VERMELHO) && (estado != VERMELHO))
                      || (estado_nx == NOTURNO) || (estado == NOTURNO);

  semaforo_ctrl_ped_latch u_ped_latch (
    .clock        (clock),
    .reset        (reset),
    .pedestre     (pedestre),
    .quinze       (tmr.quinze),
    .limpa_pedido (limpa_pedido),
    .inicio_fase  (inicio_fase),
    .encurta      (encurta),
    .pedido       (pedido),
    .encurtado    (encurtado),
    .visto_quinze (visto_quinze)
  );

  // Next phase and reload request; night mode overrides, expiry beats the pedestrian shortening.
  always_comb begin
    estado_nx = estado;
    carga_nx  = 1'b0;
    preset_nx = preset_q;
    encurta   = 1'b0;
    expira    = tmr.fim && armed;
    if (noturno) begin
      estado_nx = NOTURNO;
    end else begin
      case (estado)
        INIT: begin
          estado_nx = VERDE;
          carga_nx  = 1'b1;
          preset_nx = P_VERDE;
        end
        VERDE: begin
          if (expira) begin
            estado_nx = AMARELO;
            carga_nx  = 1'b1;
            preset_nx = P_AMARELO;
          end else if (pedido && armed && !encurtado && !visto_quinze && !tmr.quinze) begin
            carga_nx  = 1'b1;
            preset_nx = P_CURTO;
            encurta   = 1'b1;
          end
        end
        AMARELO: begin
          if (expira) begin
            estado_nx = VERMELHO;
            carga_nx  = 1'b1;
            preset_nx = P_VERMELHO;
          end
        end
        VERMELHO: begin
          if (expira) begin
            estado_nx = VERDE;
            carga_nx  = 1'b1;
            preset_nx = P_VERDE;
          end
        end
        NOTURNO: estado_nx = INIT;
        default: estado_nx = INIT;
      endcase
    end
  end

  // Lamp pattern of the phase being entered, so the registered lamps line up with the state.
  always_comb begin
    verde_nx        = 1'b0;
    amarelo_nx      = 1'b0;
    vermelho_nx     = 1'b0;
    ped_verde_nx    = 1'b0;
    ped_vermelho_nx = 1'b0;
    case (estado_nx)
      VERDE: begin
        verde_nx        = 1'b1;
        ped_vermelho_nx = 1'b1;
      end
      AMARELO: begin
        amarelo_nx      = 1'b1;
        ped_vermelho_nx = 1'b1;
      end
      VERMELHO: begin
        vermelho_nx  = 1'b1;
        ped_verde_nx = 1'b1;
      end
      NOTURNO: begin
        ped_vermelho_nx = 1'b1;
        if (estado != NOTURNO) amarelo_nx = 1'b1;
        else                   amarelo_nx = tmr.tick ? ~amarelo : amarelo;
      end
      default: begin
        vermelho_nx     = 1'b1;
        ped_vermelho_nx = 1'b1;
      end
    endcase
  end

  // State, outputs and the double-trigger guard; armed only rises once the timer has left zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INIT;
      carga_q      <= 1'b0;
      preset_q     <= '0;
      caso_q       <= 1'b1;
      verde        <= 1'b0;
      amarelo      <= 1'b0;
      vermelho     <= 1'b1;
      ped_verde    <= 1'b0;
      ped_vermelho <= 1'b1;
      armed        <= 1'b0;
    end else begin
      estado       <= estado_nx;
      carga_q      <= carga_nx;
      preset_q     <= preset_nx;
      caso_q       <= 1'b1;
      verde        <= verde_nx;
      amarelo      <= amarelo_nx;
      vermelho     <= vermelho_nx;
      ped_verde    <= ped_verde_nx;
      ped_vermelho <= ped_vermelho_nx;
      if (carga_nx)      armed <= 1'b0;
      else if (!tmr.fim) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Self-checking bench: directed vector table plus timed sequences against a countdown timer model.
module tb_semaforo_ctrl;

  localparam logic [4:0] L_G    = 5'b10001;
  localparam logic [4:0] L_A    = 5'b01001;
  localparam logic [4:0] L_R    = 5'b00110;
  localparam logic [4:0] L_INIT = 5'b00101;
  localparam logic [4:0] L_NA   = 5'b01001;
  localparam logic [4:0] L_NOFF = 5'b00001;

  typedef struct {
    logic       rst, tk, fm, qz, pd, nt;
    logic       carga;
    logic [5:0] pre;
    logic [4:0] lamps;
  } vec_t;

  logic clock = 1'b0;
  logic reset, pedestre, noturno;
  logic verde, amarelo, vermelho, ped_verde, ped_vermelho;
  logic use_model, tick_tab, fim_tab, quinze_tab, tick_gen;
  logic [4:0] cnt;
  int   div;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[29];

  semaforo_ctrl_if tif();

  assign tif.tick   = use_model ? tick_gen : tick_tab;
  assign tif.fim    = use_model ? (cnt == 5'd0) : fim_tab;
  assign tif.quinze = use_model ? (cnt == 5'd15) : quinze_tab;

  semaforo_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .tmr          (tif),
    .pedestre     (pedestre),
    .noturno      (noturno),
    .verde        (verde),
    .amarelo      (amarelo),
    .vermelho     (vermelho),
    .ped_verde    (ped_verde),
    .ped_vermelho (ped_vermelho)
  );

  always #5 clock = ~clock;

  // Countdown timer model: reload wins over tick, holds at zero because caso_esp is always high.
  always @(posedge clock) begin
    if (reset) cnt <= 5'd0;
    else if (tif.carga) cnt <= 5'(int'(tif.dez_preset) * 10 + int'(tif.unid_preset));
    else if (tif.tick && cnt != 5'd0) cnt <= cnt - 5'd1;
  end

  initial begin
    tick_gen = 1'b0;
    div = 0;
    forever begin
      @(posedge clock);
      #2;
      div = (div == 3) ? 0 : div + 1;
      tick_gen = (div == 0);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic rst, tk, fm, qz, pd, nt, cg,
                              input logic [5:0] pre, input logic [4:0] lamps);
    vec_t v;
    v.rst = rst; v.tk = tk; v.fm = fm; v.qz = qz; v.pd = pd; v.nt = nt;
    v.carga = cg; v.pre = pre; v.lamps = lamps;
    return v;
  endfunction

  function automatic logic [4:0] lamps_now();
    return {verde, amarelo, vermelho, ped_verde, ped_vermelho};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    reset      = v.rst;
    tick_tab   = v.tk;
    fim_tab    = v.fm;
    quinze_tab = v.qz;
    pedestre   = v.pd;
    noturno    = v.nt;
    @(negedge clock);
    checkOutput($sformatf("vec%0d", idx),
                int'({tif.carga, tif.dez_preset, tif.unid_preset, tif.caso_esp, lamps_now()}),
                int'({v.carga, v.pre, 1'b1, v.lamps}));
  endtask

  task automatic waitCarga(input int press_at, output logic [5:0] pre, output int ticks, output bit ok);
    bit pressed;
    pressed = 1'b0;
    ticks = 0;
    ok = 1'b0;
    pre = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      pedestre = 1'b0;
      if (tif.carga) begin
        pre = {tif.dez_preset, tif.unid_preset};
        ok = 1'b1;
        break;
      end
      if (tif.tick) ticks++;
      if (!pressed && press_at >= 0 && int'(cnt) == press_at) begin
        pedestre = 1'b1;
        pressed = 1'b1;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL carga_timeout: got no carga in 400 cycles, expected a reload");
    end
  endtask

  task automatic nextPhase(input string name, input int press_at, input logic [5:0] exp_pre,
                           input int exp_ticks, input logic [4:0] exp_lamps);
    logic [5:0] pre;
    int ticks;
    bit ok;
    waitCarga(press_at, pre, ticks, ok);
    if (ok) begin
      checkOutput({name, "_preset"}, int'(pre), int'(exp_pre));
      checkOutput({name, "_lamps"}, int'(lamps_now()), int'(exp_lamps));
      if (exp_ticks >= 0) checkOutput({name, "_ticks"}, ticks, exp_ticks);
    end
  endtask

  initial begin
    logic exp_am, tk;
    use_model = 1'b0;
    reset = 1'b1;
    pedestre = 1'b0;
    noturno = 1'b0;
    tick_tab = 1'b0;
    fim_tab = 1'b1;
    quinze_tab = 1'b0;

    vecs[0]  = mk(1,0,1,0,0,0, 0, 6'h00, L_INIT);
    vecs[1]  = mk(1,0,1,0,0,0, 0, 6'h00, L_INIT);
    vecs[2]  = mk(0,0,1,0,0,0, 1, 6'h29, L_G);
    vecs[3]  = mk(0,0,1,0,0,0, 0, 6'h29, L_G);
    vecs[4]  = mk(0,0,1,0,0,0, 0, 6'h29, L_G);
    vecs[5]  = mk(0,0,0,0,0,0, 0, 6'h29, L_G);
    vecs[6]  = mk(0,0,1,0,0,0, 1, 6'h05, L_A);
    vecs[7]  = mk(0,0,1,0,0,0, 0, 6'h05, L_A);
    vecs[8]  = mk(0,0,0,0,0,0, 0, 6'h05, L_A);
    vecs[9]  = mk(0,0,1,0,0,0, 1, 6'h20, L_R);
    vecs[10] = mk(0,0,0,0,1,0, 0, 6'h20, L_R);
    vecs[11] = mk(0,0,1,0,0,0, 1, 6'h29, L_G);
    vecs[12] = mk(0,0,0,0,0,0, 0, 6'h29, L_G);
    vecs[13] = mk(0,0,0,0,0,0, 1, 6'h15, L_G);
    vecs[14] = mk(0,0,0,1,0,0, 0, 6'h15, L_G);
    vecs[15] = mk(0,0,0,0,0,0, 0, 6'h15, L_G);
    vecs[16] = mk(0,0,1,0,0,0, 1, 6'h05, L_A);
    vecs[17] = mk(0,0,1,0,0,1, 0, 6'h05, L_NA);
    vecs[18] = mk(0,1,1,0,0,1, 0, 6'h05, L_NOFF);
    vecs[19] = mk(0,0,1,0,0,1, 0, 6'h05, L_NOFF);
    vecs[20] = mk(0,1,1,0,0,1, 0, 6'h05, L_NA);
    vecs[21] = mk(0,0,1,0,0,0, 0, 6'h05, L_INIT);
    vecs[22] = mk(0,0,1,0,0,0, 1, 6'h29, L_G);
    vecs[23] = mk(0,0,0,0,0,0, 0, 6'h29, L_G);
    vecs[24] = mk(0,0,0,0,0,0, 0, 6'h29, L_G);
    vecs[25] = mk(0,0,0,0,1,0, 0, 6'h29, L_G);
    vecs[26] = mk(0,0,0,0,0,0, 1, 6'h15, L_G);
    vecs[27] = mk(0,0,0,1,0,0, 0, 6'h15, L_G);
    vecs[28] = mk(0,0,0,0,0,0, 0, 6'h15, L_G);

    for (int i = 0; i < 29; i++) applyStimulus(i, vecs[i]);

    $display("[TB] timer model attached");
    @(negedge clock);
    use_model = 1'b1;
    reset = 1'b1;
    pedestre = 1'b0;
    noturno = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("release_carga", int'(tif.carga), 1);
    checkOutput("release_preset", int'({tif.dez_preset, tif.unid_preset}), 'h29);
    checkOutput("release_lamps", int'(lamps_now()), int'(L_G));

    nextPhase("A1", -1, 6'h05, 29, L_A);
    nextPhase("R1", -1, 6'h20, 5, L_R);
    nextPhase("G2", -1, 6'h29, 20, L_G);

    nextPhase("G2_short", 25, 6'h15, -1, L_G);
    nextPhase("A2", -1, 6'h05, 15, L_A);
    nextPhase("R2", -1, 6'h20, 5, L_R);
    nextPhase("G3", -1, 6'h29, 20, L_G);
    nextPhase("A3", -1, 6'h05, 29, L_A);

    nextPhase("R3", -1, 6'h20, 5, L_R);
    nextPhase("G4", 10, 6'h29, 20, L_G);
    nextPhase("G4_served", -1, 6'h15, -1, L_G);
    nextPhase("A4", -1, 6'h05, 15, L_A);

    nextPhase("R4", -1, 6'h20, 5, L_R);
    nextPhase("G5", -1, 6'h29, 20, L_G);
    nextPhase("A5_late_press", 10, 6'h05, 29, L_A);

    repeat (3) @(negedge clock);
    noturno = 1'b1;
    @(negedge clock);
    checkOutput("night_entry", int'({tif.carga, lamps_now()}), int'({1'b0, L_NA}));
    exp_am = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tk = tif.tick;
      @(negedge clock);
      if (tk) exp_am = ~exp_am;
      checkOutput($sformatf("night_cyc%0d", c), int'({tif.carga, lamps_now()}),
                  int'({1'b0, exp_am ? L_NA : L_NOFF}));
    end
    noturno = 1'b0;
    @(negedge clock);
    checkOutput("night_exit_init", int'({tif.carga, lamps_now()}), int'({1'b0, L_INIT}));
    @(negedge clock);
    checkOutput("night_exit_carga", int'({tif.carga, tif.dez_preset, tif.unid_preset}), int'({1'b1, 6'h29}));
    checkOutput("night_exit_lamps", int'(lamps_now()), int'(L_G));

    nextPhase("A6", -1, 6'h05, 29, L_A);
    nextPhase("R6", -1, 6'h20, 5, L_R);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_mid_red", int'({tif.carga, tif.dez_preset, tif.unid_preset, tif.caso_esp, lamps_now()}),
                int'({1'b0, 6'h00, 1'b1, L_INIT}));
    @(negedge clock);
    checkOutput("reset_hold", int'({tif.carga, lamps_now()}), int'({1'b0, L_INIT}));
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_release", int'({tif.carga, tif.dez_preset, tif.unid_preset, lamps_now()}),
                int'({1'b1, 6'h29, L_G}));
    nextPhase("A7", -1, 6'h05, 29, L_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
